// File: rtl/encap_pkg.sv
// Shared constants and FSM encoding for the DFX encap scheduler.
package encap_pkg;

   localparam int DATA_WIDTH     = 1024;
   localparam int ADDR_WIDTH     = 10;
   localparam int DATA_DFX_WIDTH = DATA_WIDTH + ADDR_WIDTH;

   // Header fields: {router id, sequence, ttl}
   localparam int RID_W        = 2;
   localparam int SEQ_W        = 5;
   localparam int TTL_W        = 2;
   localparam int HEADER_WIDTH = RID_W + SEQ_W + TTL_W;

   // Aurora beats needed to carry one DFX frame (ceil(1034/55))
   localparam int NUMBER_PACKET = 19;
   localparam int TTL_INIT      = 2;
   localparam int GAP_CYCLES    = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_SEND  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

endpackage

// File: rtl/encap_scheduler_if.sv
// Requester-side bundle of the encap scheduler: requests, frames, acks and
// the registered frame/header handed to the encapsulator.
interface encap_scheduler_if #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_DFX_WIDTH = encap_pkg::DATA_DFX_WIDTH,
   parameter int HEADER_WIDTH   = encap_pkg::HEADER_WIDTH
);
   import encap_pkg::*;

   logic                                sched_en;
   logic [NUM_REQ-1:0]                  req;
   logic [NUM_REQ*DATA_DFX_WIDTH-1:0]   data_dfx_in;
   logic [NUM_REQ-1:0]                  req_ack;
   logic                                arbiter_gnt;
   logic [DATA_DFX_WIDTH-1:0]           data_dfx_send;
   logic [HEADER_WIDTH-1:0]             header_pkt_send;
   logic                                busy;

   modport master (
      output sched_en, req, data_dfx_in,
      input  req_ack, arbiter_gnt, data_dfx_send, header_pkt_send, busy
   );

   modport slave (
      input  sched_en, req, data_dfx_in,
      output req_ack, arbiter_gnt, data_dfx_send, header_pkt_send, busy
   );

endinterface

// File: rtl/encap_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping around. Produces one-hot and binary winner plus a valid flag.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt_oh,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld
);
   import encap_pkg::*;

   int jj;

   // Scan NUM_REQ positions starting at ptr; first hit wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      jj      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         jj = int'(ptr) + i;
         if (jj >= NUM_REQ) jj = jj - NUM_REQ;
         if (!gnt_vld && req[IDX_W'(jj)]) begin
            gnt_vld              = 1'b1;
            gnt_oh[IDX_W'(jj)]   = 1'b1;
            gnt_idx              = IDX_W'(jj);
         end
      end
   end

endmodule

// File: rtl/encap_scheduler.sv
// Round-robin scheduler sharing one encap/Aurora TX path between NUM_REQ
// requesters. A grant latches the winner's frame and header, then the FSM
// stays busy for the frame's beats plus an idle gap before re-arbitrating.
module encap_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_DFX_WIDTH = encap_pkg::DATA_DFX_WIDTH,
   parameter int NUMBER_PACKET  = encap_pkg::NUMBER_PACKET,
   parameter int HEADER_WIDTH   = encap_pkg::HEADER_WIDTH,
   parameter int TTL_INIT       = encap_pkg::TTL_INIT,
   parameter int GAP_CYCLES     = encap_pkg::GAP_CYCLES
) (
   input  logic               clk,
   input  logic               rst_n,
   encap_scheduler_if.slave   bus
);
   import encap_pkg::*;

   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEAT_W = (NUMBER_PACKET > 1) ? $clog2(NUMBER_PACKET) : 1;
   localparam int GAP_W  = 4;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q;
   logic [IDX_W-1:0]   win_idx;
   logic [NUM_REQ-1:0] win_oh;
   logic               win_vld;
   logic [SEQ_W-1:0]   seq_q;
   logic [BEAT_W-1:0]  beat_q;
   logic [GAP_W-1:0]   gap_q;
   logic               grant_now;
   logic               last_beat;
   logic               last_gap;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .req     (bus.req),
      .ptr     (ptr_q),
      .gnt_oh  (win_oh),
      .gnt_idx (win_idx),
      .gnt_vld (win_vld)
   );

   // Requests are only looked at while idle; sched_en gates new grants only.
   assign grant_now = (state_q == ST_IDLE) && bus.sched_en && win_vld;
   assign last_beat = (beat_q == BEAT_W'(NUMBER_PACKET - 1));
   assign last_gap  = (gap_q == GAP_W'(GAP_CYCLES - 1));
   assign bus.busy  = (state_q != ST_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: one GRANT cycle, NUMBER_PACKET SEND beats, optional gap.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (grant_now) state_d = ST_GRANT;
         ST_GRANT: state_d = ST_SEND;
         ST_SEND:  if (last_beat) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:   if (last_gap) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Beat and gap counters run only in their own state, else parked at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
         gap_q  <= '0;
      end else begin
         beat_q <= (state_q == ST_SEND && !last_beat) ? beat_q + 1'b1 : '0;
         gap_q  <= (state_q == ST_GAP  && !last_gap)  ? gap_q + 1'b1  : '0;
      end
   end

   // Grant datapath: capture frame/header, pulse ack+strobe, advance ptr/seq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q               <= '0;
         seq_q               <= '0;
         bus.req_ack         <= '0;
         bus.arbiter_gnt     <= 1'b0;
         bus.data_dfx_send   <= '0;
         bus.header_pkt_send <= '0;
      end else begin
         bus.req_ack     <= '0;
         bus.arbiter_gnt <= 1'b0;
         if (grant_now) begin
            bus.req_ack         <= win_oh;
            bus.arbiter_gnt     <= 1'b1;
            bus.data_dfx_send   <= bus.data_dfx_in[win_idx*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];
            bus.header_pkt_send <= HEADER_WIDTH'({RID_W'(win_idx), seq_q, TTL_W'(TTL_INIT)});
            ptr_q               <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            seq_q               <= (seq_q == SEQ_W'(NUMBER_PACKET - 1)) ? '0 : seq_q + 1'b1;
         end
      end
   end

endmodule

// File: doc/encap_scheduler.md
ENCAP_SCHEDULER -- requirements
Module: encap_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one encap/Aurora TX path.
REQ-002 Parameter DATA_DFX_WIDTH, default 1034, DFX frame width (1024 data + 10 addr).
REQ-003 Parameter NUMBER_PACKET, default 19, Aurora beats per DFX frame (ceil(1034/55)).
REQ-004 Parameter HEADER_WIDTH, default 9, packet header width: 2 router-id bits, 5 sequence bits, 2 TTL bits.
REQ-005 Parameter TTL_INIT, default 2, TTL value inserted into every header.
REQ-006 Parameter GAP_CYCLES, default 1, idle cycles after each frame before next grant, range 0..15.
REQ-007 clk  input  1  clock; all logic on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 sched_en  input  1  high permits new grants; low blocks new grants only.
REQ-010 req  input  NUM_REQ  per-requester frame request, level.
REQ-011 data_dfx_in  input  NUM_REQ*DATA_DFX_WIDTH  flattened frames; requester i at slice [i*DATA_DFX_WIDTH +: DATA_DFX_WIDTH].
REQ-012 req_ack  output  NUM_REQ  one-hot, one-cycle pulse: frame of requester i captured.
REQ-013 arbiter_gnt  output  1  one-cycle load strobe to encapsulator.
REQ-014 data_dfx_send  output  DATA_DFX_WIDTH  registered selected frame.
REQ-015 header_pkt_send  output  HEADER_WIDTH  registered header {winner_idx[1:0], seq[4:0], TTL_INIT[1:0]}.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, GRANT, SEND, GAP.
REQ-018 IDLE -> GRANT SHALL occur at the edge where sched_en=1 and req!=0; otherwise IDLE holds.
REQ-019 At that edge the round-robin winner SHALL be latched, data_dfx_send loaded with its slice, header_pkt_send formed, req_ack[winner] and arbiter_gnt set.
REQ-020 GRANT SHALL last exactly one cycle; arbiter_gnt and req_ack high only in GRANT.
REQ-021 SEND SHALL last exactly NUMBER_PACKET cycles (beat counter 0..NUMBER_PACKET-1), then GAP, or IDLE if GAP_CYCLES=0.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE.
REQ-023 Minimum spacing between arbiter_gnt pulses SHALL be NUMBER_PACKET+GAP_CYCLES+2 cycles.
REQ-024 Round-robin: search starts at pointer ptr, lowest index >= ptr wrapping; after grant ptr = winner+1 mod NUM_REQ.
REQ-025 seq SHALL increment once per grant, wrapping NUMBER_PACKET-1 -> 0.
REQ-026 data_dfx_send and header_pkt_send SHALL hold value until next grant.
REQ-027 req is sampled only in IDLE; requests asserted in GRANT/SEND/GAP wait; a req deasserted before being sampled is never granted.
REQ-028 Requester may change data or drop req the cycle after req_ack.
REQ-029 sched_en low during GRANT/SEND/GAP SHALL NOT abort the frame; the FSM returns to IDLE and waits.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, ptr 0, seq 0, beat/gap counters 0, req_ack 0, arbiter_gnt 0, busy 0, data_dfx_send 0, header_pkt_send 0.
REQ-031 Reset mid-frame SHALL drop the frame with no further ack or strobe; the first grant after release uses ptr 0 and seq 0.

Structure
REQ-032 Package encap_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, DATA_DFX_WIDTH, header field widths, NUMBER_PACKET, TTL_INIT and the FSM state encoding.
REQ-033 One sub-module rr_arbiter (combinational req+ptr -> one-hot winner + index) SHALL be instantiated; the FSM, counters and muxes stay in encap_scheduler.

Verification
REQ-034 Single request: req=4'b0001, frame A5..A5 -> arbiter_gnt and req_ack=0001 one cycle after req sampled; header = {2'd0,5'd0,2'd2}; busy for 1+19+1 cycles.
REQ-035 All request: req=4'b1111 held -> grant order 0,1,2,3,0; gnt pulses exactly 22 cycles apart; seq 0,1,2,3,4.
REQ-036 Seq wrap: 20 consecutive grants -> seq runs 0..18 then 0.
REQ-037 Late request: req[2] asserted at SEND beat 5 -> no ack until IDLE; granted at first IDLE edge.
REQ-038 Enable: sched_en=0 with req=0010 -> no grant; sched_en dropped mid-SEND -> frame completes, no new grant until sched_en=1.
REQ-039 Reset at SEND beat 10 -> all outputs 0 immediately; after release req=1000 -> winner 3, header {2'd3,5'd0,2'd2}.
